// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter: shares one EMIF Avalon-MM port between the VGA frame
// fetcher (m0, read-only, may be urgent) and the HPS/blitter path (m1, r/w).
// Read commands are issued one at a time. Write bursts hold the grant until
// the last beat. A tag FIFO records {requester, beats} for each read, so that
// pipelined read data is returned to the requester that issued the read.
module ddr3_port_arbiter #(
    parameter int ADDR_W    = 27,
    parameter int DATA_W    = 128,
    parameter int BURST_W   = 7,
    parameter int TAG_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  init_done,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic [BURST_W-1:0]    m0_burstcount,
    input  logic                  m0_urgent,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic [BURST_W-1:0]    m1_burstcount,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    output logic [BURST_W-1:0]    s_burstcount,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]   TAG_FULL = CNT_W'(TAG_DEPTH);
    localparam logic [BURST_W-1:0] ONE      = BURST_W'(1);

    typedef enum logic [1:0] {IDLE, RD_CMD, WR_BURST} state_t;
    typedef struct packed {
        logic               id;
        logic [BURST_W-1:0] beats;
    } tag_t;

    state_t             state;
    logic               grant;
    logic               last_grant;
    logic [BURST_W-1:0] wr_beats;

    tag_t               tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   tag_cnt, tag_cnt_next;
    logic               tag_full;
    logic [BURST_W-1:0] head_done;

    logic               m0_elig, m1_elig, arb_valid, arb_grant;
    logic [BURST_W-1:0] rd_bc;
    logic               tag_push, tag_pop, rd_beat, head_last;
    tag_t               head;

    // A zero burstcount is treated as a single beat.
    function automatic logic [BURST_W-1:0] norm_bc(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? ONE : bc;
    endfunction

    // Arbitration decision, used only in IDLE: urgent VGA first, then round-robin
    always_comb begin
        m0_elig   = m0_read && !tag_full;
        m1_elig   = (m1_read && !tag_full) || m1_write;
        arb_valid = init_done && (m0_elig || m1_elig);
        if (m0_urgent && m0_elig)
            arb_grant = 1'b0;
        else if (m0_elig && m1_elig)
            arb_grant = ~last_grant;
        else
            arb_grant = m1_elig;
    end

    // Tag FIFO push/pop decode. Head beat tracking for read return routing.
    always_comb begin
        rd_bc        = grant ? m1_burstcount : m0_burstcount;
        tag_push     = (state == RD_CMD) && !s_waitrequest;
        head         = tag_mem[rd_ptr];
        rd_beat      = s_readdatavalid && (tag_cnt != '0);
        head_last    = (head_done == head.beats - ONE);
        tag_pop      = rd_beat && head_last;
        tag_cnt_next = tag_cnt + CNT_W'(tag_push) - CNT_W'(tag_pop);
    end

    // EMIF command side is muxed from the granted requester. It is idle in IDLE.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        s_burstcount = ONE;
        case (state)
            RD_CMD: begin
                s_read       = 1'b1;
                s_address    = grant ? m1_address : m0_address;
                s_byteenable = '1;
                s_burstcount = rd_bc;
            end
            WR_BURST: begin
                // m1 may insert idle cycles mid-burst; s_write simply follows it
                s_write      = m1_write;
                s_address    = m1_address;
                s_writedata  = m1_writedata;
                s_byteenable = m1_byteenable;
                s_burstcount = m1_burstcount;
            end
            default: ;
        endcase
    end

    // Handshake back to the requesters and read-data fan-out by head tag
    always_comb begin
        m0_waitrequest   = !((state == RD_CMD) && !grant && !s_waitrequest);
        m1_waitrequest   = !(((state == RD_CMD) || (state == WR_BURST)) && grant && !s_waitrequest);
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = rd_beat && !head.id;
        m1_readdatavalid = rd_beat && head.id;
    end

    // Command sequencer: arbitrate, issue one read, or hold grant for a write burst
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            wr_beats   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant      <= arb_grant;
                        last_grant <= arb_grant;
                        if (arb_grant && m1_write) begin
                            state    <= WR_BURST;
                            wr_beats <= norm_bc(m1_burstcount);
                        end else begin
                            state <= RD_CMD;
                        end
                    end
                end
                RD_CMD: begin
                    if (!s_waitrequest)
                        state <= IDLE;
                end
                WR_BURST: begin
                    if (m1_write && !s_waitrequest) begin
                        if (wr_beats == ONE)
                            state <= IDLE;
                        else
                            wr_beats <= wr_beats - ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag storage, with no reset. The pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (tag_push)
            tag_mem[wr_ptr] <= '{id: grant, beats: norm_bc(rd_bc)};
    end

    // Tag FIFO pointers, occupancy, registered full flag and head beat counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            tag_cnt   <= '0;
            tag_full  <= 1'b0;
            head_done <= '0;
        end else begin
            if (tag_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_beat) begin
                if (head_last) begin
                    rd_ptr    <= rd_ptr + 1'b1;
                    head_done <= '0;
                end else begin
                    head_done <= head_done + ONE;
                end
            end
            tag_cnt  <= tag_cnt_next;
            tag_full <= (tag_cnt_next == TAG_FULL);
        end
    end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Scoreboard bench for ddr3_port_arbiter. A cycle-stepped EMIF model returns
// read data derived from the address. The bench pushes the expected
// requester and data for each beat when a master command is accepted, and
// pops and compares them as beats come back.
module tb_ddr3_port_arbiter;

    localparam int AW = 27;
    localparam int DW = 128;
    localparam int BW = 7;

    typedef struct { logic [AW-1:0] a; logic [BW-1:0] bc; } rdcmd_t;
    typedef struct { logic id; logic [DW-1:0] d; } exp_t;
    typedef struct { int cyc; logic [AW-1:0] a; logic [BW-1:0] bc; } log_t;
    typedef struct { logic v; logic [AW-1:0] a; logic [BW-1:0] bc; logic [DW-1:0] d; logic [DW/8-1:0] be; } wbeat_t;
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; logic [DW/8-1:0] be; } expw_t;

    logic              clk = 1'b0;
    logic              reset_n, init_done;
    logic [AW-1:0]     m0_address, m1_address, s_address;
    logic              m0_read, m0_urgent, m0_waitrequest, m0_readdatavalid;
    logic [BW-1:0]     m0_burstcount, m1_burstcount, s_burstcount;
    logic [DW-1:0]     m0_readdata, m1_readdata, m1_writedata, s_writedata, s_readdata;
    logic              m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
    logic [DW/8-1:0]   m1_byteenable, s_byteenable;
    logic              s_read, s_write, s_waitrequest, s_readdatavalid;

    rdcmd_t    m0_q[$], m1_q[$];
    wbeat_t    wr_q[$];
    exp_t      exp_q[$];
    expw_t     expw_q[$];
    logic [DW-1:0] emif_q[$];
    log_t      log_q[$];

    int total = 0, bad = 0, cyc = 0;
    int wr_cnt = 0, wr_last_cyc = 0, rv0_cnt = 0, rv1_cnt = 0;
    int ret_budget = -1;
    int t0;

    always #5 clk = ~clk;

    ddr3_port_arbiter dut (
        .clk(clk), .reset_n(reset_n), .init_done(init_done),
        .m0_address(m0_address), .m0_read(m0_read), .m0_burstcount(m0_burstcount),
        .m0_urgent(m0_urgent), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_burstcount(m1_burstcount), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {5'd0, a} ^ 32'h5A5A0000;
        return {w, ~w, w + 32'd1, w ^ 32'h0000FFFF};
    endfunction

    task automatic drive_masters();
        m0_read       = (m0_q.size() != 0);
        m0_address    = m0_read ? m0_q[0].a : '0;
        m0_burstcount = m0_read ? m0_q[0].bc : '0;
        m1_read       = (m1_q.size() != 0);
        if (wr_q.size() != 0) begin
            m1_write      = wr_q[0].v;
            m1_address    = wr_q[0].a;
            m1_burstcount = wr_q[0].bc;
            m1_writedata  = wr_q[0].d;
            m1_byteenable = wr_q[0].be;
        end else begin
            m1_write      = 1'b0;
            m1_address    = m1_read ? m1_q[0].a : '0;
            m1_burstcount = m1_read ? m1_q[0].bc : '0;
            m1_writedata  = '0;
            m1_byteenable = '0;
        end
    endtask

    // queue a write burst of n beats with an optional idle cycle after beat gap
    task automatic q_wr(input logic [AW-1:0] a, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0]   d;
            logic [DW/8-1:0] be;
            d  = ~mkdata(a + AW'(i));
            be = 16'hFFFF >> i;
            wr_q.push_back('{1'b1, a, BW'(n), d, be});
            expw_q.push_back('{a, d, be});
            if (i == gap)
                wr_q.push_back('{1'b0, a, BW'(n), '0, '0});
        end
    endtask

    // one clock: observe at negedge, advance models, drive next inputs after posedge
    task automatic cycle();
        logic m0_acc, m1_acc, w_acc;
        int n;
        @(negedge clk);
        cyc++;
        if (m0_readdatavalid) rv0_cnt++;
        if (m1_readdatavalid) rv1_cnt++;
        if (s_readdatavalid) begin
            if (exp_q.size() == 0) begin
                chk("drop_v0", m0_readdatavalid, 0);
                chk("drop_v1", m1_readdatavalid, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("route_v0", m0_readdatavalid, !e.id);
                chk("route_v1", m1_readdatavalid, e.id);
                chk("rdata", e.id ? m1_readdata : m0_readdata, e.d);
            end
        end else if (m0_readdatavalid || m1_readdatavalid) begin
            chk("spurious_valid", 1, 0);
        end
        if (reset_n && s_read && !s_waitrequest) begin
            n = (s_burstcount == 0) ? 1 : int'(s_burstcount);
            for (int i = 0; i < n; i++) emif_q.push_back(mkdata(s_address + AW'(i)));
            log_q.push_back('{cyc, s_address, s_burstcount});
        end
        if (reset_n && s_write && !s_waitrequest) begin
            wr_cnt++;
            wr_last_cyc = cyc;
            if (expw_q.size() == 0) begin
                chk("wr_extra", 1, 0);
            end else begin
                expw_t w;
                w = expw_q.pop_front();
                chk("wdata", s_writedata, w.d);
                chk("wbe", s_byteenable, w.be);
                chk("waddr", s_address, w.a);
            end
        end
        m0_acc = m0_read && !m0_waitrequest;
        m1_acc = m1_read && !m1_waitrequest;
        w_acc  = m1_write && !m1_waitrequest;
        if (m0_acc) begin
            n = (m0_burstcount == 0) ? 1 : int'(m0_burstcount);
            for (int i = 0; i < n; i++) exp_q.push_back('{1'b0, mkdata(m0_address + AW'(i))});
        end
        if (m1_acc) begin
            n = (m1_burstcount == 0) ? 1 : int'(m1_burstcount);
            for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, mkdata(m1_address + AW'(i))});
        end
        @(posedge clk);
        #1;
        if (m0_acc) void'(m0_q.pop_front());
        if (m1_acc) void'(m1_q.pop_front());
        if (wr_q.size() != 0 && (w_acc || !wr_q[0].v)) void'(wr_q.pop_front());
        drive_masters();
        if (ret_budget != 0 && emif_q.size() != 0) begin
            s_readdatavalid = 1'b1;
            s_readdata      = emif_q.pop_front();
            if (ret_budget > 0) ret_budget--;
        end else begin
            s_readdatavalid = 1'b0;
        end
    endtask

    task automatic clr_all();
        m0_q.delete(); m1_q.delete(); wr_q.delete(); exp_q.delete();
        expw_q.delete(); emif_q.delete(); log_q.delete();
        wr_cnt = 0; rv0_cnt = 0; rv1_cnt = 0;
    endtask

    task automatic rst();
        reset_n = 1'b0;
        clr_all();
        drive_masters();
        s_readdatavalid = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
        clr_all();
    endtask

    task automatic drain(input string tag, input int max);
        int k;
        k = 0;
        while ((m0_q.size() || m1_q.size() || wr_q.size() || exp_q.size() || emif_q.size()) && k < max) begin
            cycle();
            k++;
        end
        chk({tag, "_drain_timeout"}, k >= max, 0);
    endtask

    initial begin
        reset_n = 1'b0; init_done = 1'b0; m0_urgent = 1'b0;
        s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
        drive_masters();
        cycle();
        cycle();
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_s_addr", s_address, 0);
        chk("rst_s_bc", s_burstcount, 1);
        chk("rst_s_be", s_byteenable, 0);
        chk("rst_s_wd", s_writedata, 0);
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_m0_rdv", m0_readdatavalid, 0);
        chk("rst_m1_rdv", m1_readdatavalid, 0);
        reset_n = 1'b1;
        init_done = 1'b1;

        // single m0 burst 8: command timing and routing
        m0_q.push_back('{27'h100, 7'd8});
        drive_masters();
        t0 = cyc + 1;
        drain("t1", 100);
        chk("t1_ncmd", log_q.size(), 1);
        if (log_q.size() != 0) begin
            chk("t1_cyc", log_q[0].cyc, t0 + 1);
            chk("t1_bc", log_q[0].bc, 8);
            chk("t1_addr", log_q[0].a, 27'h100);
        end
        chk("t1_rv0", rv0_cnt, 8);
        chk("t1_rv1", rv1_cnt, 0);

        // simultaneous reads from reset: m0 wins the first tie
        rst();
        m0_q.push_back('{27'h200, 7'd2});
        m1_q.push_back('{27'h300, 7'd3});
        drive_masters();
        drain("t2", 100);
        chk("t2_ncmd", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t2_first", log_q[0].a, 27'h200);
            chk("t2_second", log_q[1].a, 27'h300);
        end

        // urgent held: every m0 read wins before any m1 read
        log_q.delete();
        m0_urgent = 1'b1;
        for (int i = 0; i < 3; i++) m0_q.push_back('{AW'(27'h400 + i), 7'd1});
        for (int i = 0; i < 2; i++) m1_q.push_back('{AW'(27'h500 + i), 7'd1});
        drive_masters();
        drain("t2u", 100);
        chk("t2u_ncmd", log_q.size(), 5);
        if (log_q.size() == 5)
            for (int i = 0; i < 5; i++)
                chk($sformatf("t2u_ord%0d", i), log_q[i].a, (i < 3) ? 27'h400 + i : 27'h500 + i - 3);

        // write burst with a mid-burst bubble; urgent m0 must wait for the end
        log_q.delete();
        q_wr(27'h600, 4, 1);
        drive_masters();
        cycle();
        m0_q.push_back('{27'h700, 7'd1});
        drive_masters();
        drain("t3", 100);
        m0_urgent = 1'b0;
        chk("t3_wbeats", wr_cnt, 4);
        chk("t3_wleft", expw_q.size(), 0);
        chk("t3_ncmd", log_q.size(), 1);
        if (log_q.size() == 1)
            chk("t3_rd_after_wr", log_q[0].cyc > wr_last_cyc, 1);

        // tag FIFO full: 9th read held until the first burst fully returns
        rst();
        ret_budget = 0;
        for (int i = 0; i < 9; i++) m0_q.push_back('{AW'(27'h1000 + 16 * i), 7'd2});
        drive_masters();
        for (int i = 0; i < 40; i++) cycle();
        chk("t4_held", log_q.size(), 8);
        chk("t4_wait", m0_waitrequest, 1);
        ret_budget = 1;
        for (int i = 0; i < 6; i++) cycle();
        chk("t4_held_1beat", log_q.size(), 8);
        ret_budget = 1;
        for (int i = 0; i < 6; i++) cycle();
        chk("t4_released", log_q.size(), 9);
        ret_budget = -1;
        drain("t4", 200);
        chk("t4_rv0", rv0_cnt, 18);

        // interleaved m0 burst 4 / m1 burst 2, returned after both are issued
        rst();
        ret_budget = 0;
        m0_q.push_back('{27'h800, 7'd4});
        m1_q.push_back('{27'h900, 7'd2});
        drive_masters();
        for (int i = 0; i < 20 && (m0_q.size() || m1_q.size()); i++) cycle();
        ret_budget = -1;
        drain("t5", 100);
        chk("t5_rv0", rv0_cnt, 4);
        chk("t5_rv1", rv1_cnt, 2);

        // burstcount 0 forwarded as-is but tracked as one beat
        log_q.delete();
        m0_q.push_back('{27'hA00, 7'd0});
        m1_q.push_back('{27'hB00, 7'd2});
        drive_masters();
        drain("t5z", 100);
        if (log_q.size() != 0) chk("t5z_fwd0", log_q[0].bc, 0);
        chk("t5z_rv1", rv1_cnt, 4);

        // init_done low: nothing issued until it rises
        rst();
        init_done = 1'b0;
        m0_q.push_back('{27'hD00, 7'd1});
        q_wr(27'hE00, 2, -1);
        drive_masters();
        for (int i = 0; i < 10; i++) cycle();
        chk("t6_no_rd", log_q.size(), 0);
        chk("t6_no_wr", wr_cnt, 0);
        init_done = 1'b1;
        drain("t6", 100);
        chk("t6_rd", log_q.size(), 1);
        chk("t6_wr", wr_cnt, 2);

        // reset in the middle of a write burst
        rst();
        q_wr(27'hF00, 4, -1);
        drive_masters();
        cycle();
        cycle();
        cycle();
        reset_n = 1'b0;
        cycle();
        chk("t6r_s_write", s_write, 0);
        chk("t6r_m0_wait", m0_waitrequest, 1);
        chk("t6r_m1_wait", m1_waitrequest, 1);
        chk("t6r_beats", wr_cnt, 2);
        rst();

        // outstanding tag discarded by reset: a stray beat goes nowhere
        ret_budget = 0;
        m0_q.push_back('{27'hC00, 7'd2});
        drive_masters();
        for (int i = 0; i < 10 && m0_q.size(); i++) cycle();
        rst();
        emif_q.push_back(mkdata(27'h0));
        ret_budget = 1;
        cycle();
        cycle();
        cycle();
        chk("t6d_no_valid", rv0_cnt + rv1_cnt, 0);
        ret_budget = -1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
